// File: rtl/lsu.sv
// Load/store unit for the memory stage: one req/ack data-memory transaction per
// accepted request, with byte-enable generation, store lane replication and load extension.
module lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] StoreData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Fault,
  output logic [DATA_WIDTH-1:0] LoadData,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [DATA_WIDTH-1:0] MemAddr,
  output logic [3:0]            MemBE,
  output logic [DATA_WIDTH-1:0] MemWData,
  input  logic [DATA_WIDTH-1:0] MemRData,
  input  logic                  MemAck
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  is_load_q, is_load_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;

  logic [1:0]            off;
  logic [1:0]            sz;
  logic                  misalign;
  logic                  bad_f3;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext;

  // Request decode on the live inputs; only consumed when a request is accepted.
  always_comb begin
    off      = ALUResult[1:0];
    sz       = Funct3[1:0];
    misalign = ((sz == 2'b01) && off[0]) || ((sz == 2'b10) && (off != 2'b00));
    // Width code 11 has no RV32I encoding for either direction.
    bad_f3   = MemRead ? ((sz == 2'b11) || (Funct3 == 3'b110))
                       : (Funct3[2] || (sz == 2'b11));
    be       = 4'b1111;
    wdata    = StoreData;
    case (sz)
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{StoreData[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << off;
        wdata = {2{StoreData[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = StoreData;
      end
    endcase
    if (MemRead) begin
      wdata = '0;
    end
  end

  always_comb begin
    shifted = MemRData >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fault_d     = fault_q;
    load_data_d = load_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    is_load_d   = is_load_q;
    funct3_d    = funct3_q;
    off_d       = off_q;

    case (state_q)
      IDLE: begin
        if (Start && (MemRead ^ MemWrite)) begin
          busy_d      = 1'b1;
          mem_we_d    = MemWrite;
          mem_addr_d  = {ALUResult[DATA_WIDTH-1:2], 2'b00};
          mem_be_d    = be;
          mem_wdata_d = wdata;
          is_load_d   = MemRead;
          funct3_d    = Funct3;
          off_d       = off;
          if (misalign || bad_f3) begin
            state_d     = DONE;
            done_d      = 1'b1;
            fault_d     = 1'b1;
            load_data_d = '0;
          end else begin
            state_d   = WAIT;
            mem_req_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (MemAck) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (is_load_q) begin
            load_data_d = ext;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        fault_d = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        fault_d   = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      is_load_q   <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      is_load_q   <= is_load_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Fault    = fault_q;
  assign LoadData = load_data_q;
  assign MemReq   = mem_req_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemBE    = mem_be_q;
  assign MemWData = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected memory requests and completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = '0;
  logic [31:0] ALUResult = '0;
  logic [31:0] StoreData = '0;
  logic        Busy, Done, Fault, MemReq, MemWe;
  logic [31:0] LoadData, MemAddr, MemWData;
  logic [3:0]  MemBE;
  logic [31:0] MemRData = '0;
  logic        MemAck = 1'b0;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  logic        req_prev = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    logic        flt;
    logic [31:0] ld;
    int unsigned t0;
    int unsigned lat;
  } dn_t;

  req_t req_q[$];
  dn_t  dn_q[$];

  lsu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .StoreData(StoreData), .Busy(Busy),
    .Done(Done), .Fault(Fault), .LoadData(LoadData), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemBE(MemBE), .MemWData(MemWData), .MemRData(MemRData),
    .MemAck(MemAck)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: request contents while MemReq is high, completions on Done.
  always @(negedge clk) begin
    if (MemReq) begin
      if (req_q.size() == 0) begin
        chk("unexpected_req", 32'(MemReq), 32'd0);
      end else begin
        chk("req_we", 32'(MemWe), 32'(req_q[0].we));
        chk("req_addr", MemAddr, req_q[0].addr);
        chk("req_be", 32'(MemBE), 32'(req_q[0].be));
        chk("req_wdata", MemWData, req_q[0].wd);
        chk("req_busy", 32'(Busy), 32'd1);
      end
    end else if (req_prev && req_q.size() > 0) begin
      void'(req_q.pop_front());
    end
    req_prev = MemReq;
    if (Done) begin
      if (dn_q.size() == 0) begin
        chk("unexpected_done", 32'(Done), 32'd0);
      end else begin
        dn_t e;
        e = dn_q.pop_front();
        chk("done_fault", 32'(Fault), 32'(e.flt));
        chk("done_loaddata", LoadData, e.ld);
        chk("done_latency", cyc - e.t0, e.lat);
        chk("done_busy", 32'(Busy), 32'd1);
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < 10; i++) begin
      if (!Busy) break;
      @(negedge clk);
    end
    chk(name, 32'(Busy), 32'd0);
  endtask

  // ackc: cycle in which MemAck is high (1 = immediate ack).
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] sdata,
                     input logic [31:0] rdata, input int unsigned ackc,
                     input logic flt, input logic [31:0] ld,
                     input logic [3:0] be, input logic [31:0] wd);
    req_t r;
    dn_t  d;
    @(negedge clk);
    chk("idle_before", 32'(Busy), 32'd0);
    Start = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3;
    ALUResult = addr; StoreData = sdata;
    d.flt = flt; d.ld = ld; d.t0 = cyc; d.lat = flt ? 1 : ackc + 1;
    dn_q.push_back(d);
    if (!flt) begin
      r.we = wr; r.addr = {addr[31:2], 2'b00}; r.be = be; r.wd = wd;
      req_q.push_back(r);
    end
    @(negedge clk);
    Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    if (!flt) begin
      repeat (ackc - 1) @(negedge clk);
      MemAck = 1'b1; MemRData = rdata;
      @(negedge clk);
      MemAck = 1'b0;
    end
    wait_idle("idle_after");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    chk("rst_memreq", 32'(MemReq), 32'd0);
    chk("rst_memwe", 32'(MemWe), 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_membe", 32'(MemBE), 32'd0);
    chk("rst_memwdata", MemWData, 32'd0);
    chk("rst_loaddata", LoadData, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    //   rd    wr    f3      addr          sdata         rdata        ack flt ld            be       wd
    txn(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        3, 0, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF);
    txn(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_1234, 1, 0, 32'hFFFF_FF80, 4'b1000, 32'h0);
    txn(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_1234, 1, 0, 32'h0000_0080, 4'b1000, 32'h0);
    txn(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'h80FF_1234, 1, 0, 32'hFFFF_80FF, 4'b1100, 32'h0);
    txn(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,         32'h80FF_1234, 1, 0, 32'h0000_80FF, 4'b1100, 32'h0);
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h80FF_1234, 1, 0, 32'h80FF_1234, 4'b1111, 32'h0);
    txn(1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,         32'h0000_7F00, 2, 0, 32'h0000_007F, 4'b0010, 32'h0);
    txn(1'b0, 1'b1, 3'b000, 32'h0000_0102, 32'h0000_00AB, 32'h0,        1, 0, 32'h0000_007F, 4'b0100, 32'hABAB_ABAB);
    txn(1'b0, 1'b1, 3'b001, 32'h0000_0100, 32'h1234_ABCD, 32'h0,        1, 0, 32'h0000_007F, 4'b0011, 32'hABCD_ABCD);
    txn(1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h1234_5678, 32'h0,        1, 1, 32'h0000_0000, 4'b0000, 32'h0);
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,         32'h0,        1, 1, 32'h0000_0000, 4'b0000, 32'h0);
    txn(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,        1, 1, 32'h0000_0000, 4'b0000, 32'h0);
    txn(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,         32'h0,        1, 1, 32'h0000_0000, 4'b0000, 32'h0);

    // Start pulses while in WAIT and in DONE must not start a second transaction.
    begin
      req_t r;
      dn_t  d;
      @(negedge clk);
      Start = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_0200;
      d.flt = 1'b0; d.ld = 32'h1122_3344; d.t0 = cyc; d.lat = 4;
      dn_q.push_back(d);
      r.we = 1'b0; r.addr = 32'h0000_0200; r.be = 4'b1111; r.wd = 32'h0;
      req_q.push_back(r);
      @(negedge clk); Start = 1'b0;
      @(negedge clk); Start = 1'b1;
      @(negedge clk); Start = 1'b0; MemAck = 1'b1; MemRData = 32'h1122_3344;
      @(negedge clk); MemAck = 1'b0; Start = 1'b1;
      @(negedge clk); Start = 1'b0; MemRead = 1'b0;
      chk("dup_busy", 32'(Busy), 32'd0);
      repeat (2) @(negedge clk);
      chk("dup_busy_later", 32'(Busy), 32'd0);
    end

    // Both MemRead and MemWrite set: ignored.
    @(negedge clk);
    Start = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_0100;
    @(negedge clk);
    Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    chk("both_busy", 32'(Busy), 32'd0);
    chk("both_memreq", 32'(MemReq), 32'd0);

    // Reset during WAIT: request dropped asynchronously, no completion.
    begin
      req_t r;
      @(negedge clk);
      Start = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_0300;
      r.we = 1'b0; r.addr = 32'h0000_0300; r.be = 4'b1111; r.wd = 32'h0;
      req_q.push_back(r);
      @(negedge clk); Start = 1'b0; MemRead = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_memreq", 32'(MemReq), 32'd0);
      chk("rst_async_busy", 32'(Busy), 32'd0);
      @(negedge clk); reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_no_busy", 32'(Busy), 32'd0);
    end

    txn(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 2, 0, 32'hCAFE_F00D, 4'b1111, 32'h0);

    repeat (3) @(negedge clk);
    chk("req_queue_empty", 32'(req_q.size()), 32'd0);
    chk("done_queue_empty", 32'(dn_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
